// File: rtl/fft_dma_engine.sv
// fft_dma_engine
//   Moves FFT_N complex Q1.15 samples between the word-wide data memory and the
//   FFT core. On an accepted start it reads W=FFT_N/2 packed RE words and then
//   W packed IM words, unpacks them onto the core's flat input buses, pulses
//   fft_start, waits for fft_done, captures the core's flat outputs, and writes
//   them back in place (RE words first, then IM words) before pulsing done.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               one-cycle request, honoured only while idle
//   re_base, im_base    byte bases of the RE / IM regions (low 2 bits ignored)
//   busy, done          activity flag / one-cycle completion pulse
//   mem_addr            word-aligned byte address for reads and writes
//   mem_rd_en           read strobe, data on mem_rdata one cycle later
//   mem_wr_en           full-word write strobe with mem_wdata
//   mem_rdata           read data
//   fft_start           one-cycle launch pulse to the core
//   fft_done            core completion (level or pulse)
//   fft_in_*_flat       core inputs, sample i at [i*DATA_W +: DATA_W]
//   fft_out_*_flat      core results, same layout, valid with fft_done
// Memory word k holds {sample[2k+1], sample[2k]}.
module fft_dma_engine #(
  parameter int FFT_N  = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         re_base,
  input  logic [ADDR_W-1:0]         im_base,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_rd_en,
  output logic                      mem_wr_en,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata,
  output logic                      fft_start,
  input  logic                      fft_done,
  output logic [FFT_N*DATA_W-1:0]   fft_in_re_flat,
  output logic [FFT_N*DATA_W-1:0]   fft_in_im_flat,
  input  logic [FFT_N*DATA_W-1:0]   fft_out_re_flat,
  input  logic [FFT_N*DATA_W-1:0]   fft_out_im_flat
);

  localparam int W  = FFT_N / 2;
  localparam int CW = $clog2(2 * W) + 1;
  localparam int FW = FFT_N * DATA_W;
  localparam int PW = 2 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_DRAIN,
    S_LAUNCH,
    S_WAIT,
    S_WR,
    S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]   re_base_q, re_base_d;
  logic [ADDR_W-1:0]   im_base_q, im_base_d;

  logic                cap_vld_q;
  logic [CW-1:0]       cap_idx_q;
  logic [FW-1:0]       in_re_q, in_im_q;
  logic [FW-1:0]       res_re_q, res_im_q;

  // Word index within the current region for the transfer counter and for
  // the delayed read-capture index; counts W..2W-1 address the IM region.
  logic                cnt_is_im;
  logic [CW-1:0]       widx;
  logic                cap_is_im;
  logic [CW-1:0]       cap_word;

  assign cnt_is_im = (cnt_q >= CW'(W));
  assign widx      = cnt_is_im ? (cnt_q - CW'(W)) : cnt_q;
  assign cap_is_im = (cap_idx_q >= CW'(W));
  assign cap_word  = cap_is_im ? (cap_idx_q - CW'(W)) : cap_idx_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      re_base_q <= '0;
      im_base_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      re_base_q <= re_base_d;
      im_base_q <= im_base_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    re_base_d = re_base_q;
    im_base_d = im_base_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          re_base_d = {re_base[ADDR_W-1:2], 2'b00};
          im_base_d = {im_base[ADDR_W-1:2], 2'b00};
          cnt_d     = '0;
          state_d   = S_RD;
        end
      end
      S_RD: begin
        if (cnt_q == CW'(2 * W - 1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN:  state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (fft_done) state_d = S_WR;
      end
      S_WR: begin
        if (cnt_q == CW'(2 * W - 1)) begin
          cnt_d   = '0;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; memory strobes decode straight from the state register so a
  // reset removes them without waiting for a clock edge.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_FIN);
    fft_start = (state_q == S_LAUNCH);
    mem_rd_en = (state_q == S_RD);
    mem_wr_en = (state_q == S_WR);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == S_RD || state_q == S_WR) begin
      mem_addr = (cnt_is_im ? im_base_q : re_base_q) + ADDR_W'({widx, 2'b00});
    end
    if (state_q == S_WR) begin
      mem_wdata = 32'(cnt_is_im ? res_im_q[widx * PW +: PW]
                                : res_re_q[widx * PW +: PW]);
    end
  end

  // Datapath: read data lands one cycle after issue, so the capture index is
  // the counter value delayed by one cycle; DRAIN picks up the final IM word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      in_re_q   <= '0;
      in_im_q   <= '0;
      res_re_q  <= '0;
      res_im_q  <= '0;
    end else begin
      cap_vld_q <= (state_q == S_RD);
      cap_idx_q <= cnt_q;
      if (cap_vld_q) begin
        if (cap_is_im) in_im_q[cap_word * PW +: PW] <= mem_rdata[PW-1:0];
        else           in_re_q[cap_word * PW +: PW] <= mem_rdata[PW-1:0];
      end
      if (state_q == S_WAIT && fft_done) begin
        res_re_q <= fft_out_re_flat;
        res_im_q <= fft_out_im_flat;
      end
    end
  end

  assign fft_in_re_flat = in_re_q;
  assign fft_in_im_flat = in_im_q;

endmodule

// File: tb/tb_fft_dma_engine.sv
// Testbench for fft_dma_engine: memory and FFT-core stubs, table of directed
// and randomized transfers checked against a sample-level reference model,
// plus a reset-during-write-back sequence.
module tb_fft_dma_engine;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int W  = N / 2;
  localparam int FW = N * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] re_base = '0;
  logic [AW-1:0] im_base = '0;
  logic          busy, done;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en, mem_wr_en;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          fft_start;
  logic          fft_done = 1'b0;
  logic [FW-1:0] fft_in_re_flat, fft_in_im_flat;
  logic [FW-1:0] fft_out_re_flat = '0;
  logic [FW-1:0] fft_out_im_flat = '0;

  always #5 clk = ~clk;

  fft_dma_engine #(.FFT_N(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .re_base(re_base), .im_base(im_base),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fft_start(fft_start), .fft_done(fft_done),
    .fft_in_re_flat(fft_in_re_flat), .fft_in_im_flat(fft_in_im_flat),
    .fft_out_re_flat(fft_out_re_flat), .fft_out_im_flat(fft_out_im_flat)
  );

  // Memory image (written only by the stimulus) and a log of DUT writes.
  logic [31:0] mem [int unsigned];
  logic [63:0] wr_q [$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // Event monitor; cycle k means the value present just before posedge k.
  int cyc = 0, st_cyc = 0, fs_cyc = 0, fd_cyc = 0, dn_cyc = 0;
  int fs_cnt = 0, dn_cnt = 0, overlap = 0;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem_rd(mem_addr);
    if (mem_wr_en) wr_q.push_back({mem_addr, mem_wdata});
    if (mem_rd_en && mem_wr_en) overlap <= overlap + 1;
    if (start && !busy) st_cyc <= cyc;
    if (fft_start) begin
      fs_cyc <= cyc;
      fs_cnt <= fs_cnt + 1;
    end
    if (fft_done) fd_cyc <= cyc;
    if (done) begin
      dn_cyc <= cyc;
      dn_cnt <= dn_cnt + 1;
    end
    cyc <= cyc + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0]   rb;
    logic [31:0]   ib;
    logic [FW-1:0] re_w;     // memory word k at [32k +: 32]
    logic [FW-1:0] im_w;
    logic [FW-1:0] co_re;    // core result sample i at [16i +: 16]
    logic [FW-1:0] co_im;
    logic [3:0]    dly;
    logic          noise;    // pulse fft_done in RD and start in WAIT
    logic          rnd;      // expected fields come from the model
    logic [FW-1:0] x_in_re;  // expected core input samples
    logic [FW-1:0] x_in_im;
    logic [FW-1:0] x_wb_re;  // expected written-back words
    logic [FW-1:0] x_wb_im;
  } vec_t;

  localparam int NV = 7;
  vec_t tv [NV];

  // Reference model: memory words -> sample list, sample list -> memory words.
  function automatic logic [FW-1:0] words_to_samples(input logic [FW-1:0] words);
    logic [DW-1:0] s [N];
    logic [31:0]   wd;
    logic [FW-1:0] r;
    for (int i = 0; i < N; i++) begin
      wd   = words[(i / 2) * 32 +: 32];
      s[i] = (i % 2 == 0) ? wd[15:0] : wd[31:16];
    end
    r = '0;
    for (int i = 0; i < N; i++) r[i * DW +: DW] = s[i];
    return r;
  endfunction

  function automatic logic [FW-1:0] samples_to_words(input logic [FW-1:0] smp);
    logic [FW-1:0] r;
    logic [15:0]   lo, hi;
    r = '0;
    for (int k = 0; k < W; k++) begin
      lo = smp[(2 * k) * DW +: DW];
      hi = smp[(2 * k + 1) * DW +: DW];
      r[k * 32 +: 32] = {hi, lo};
    end
    return r;
  endfunction

  function automatic logic [FW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic preload(input vec_t v);
    mem.delete();
    wr_q.delete();
    for (int k = 0; k < W; k++) begin
      mem[align(v.rb) + 32'(4 * k)] = v.re_w[k * 32 +: 32];
      mem[align(v.ib) + 32'(4 * k)] = v.im_w[k * 32 +: 32];
    end
  endtask

  // Issue start, wait for fft_start; returns with the engine in WAIT.
  task automatic launch(input vec_t v, input string tag, output bit ok);
    int fs0, w;
    fs0 = fs_cnt;
    @(negedge clk);
    start = 1'b1; re_base = v.rb; im_base = v.ib;
    fft_out_re_flat = ~v.co_re; fft_out_im_flat = ~v.co_im;
    @(negedge clk);
    start = 1'b0; re_base = $urandom; im_base = $urandom;
    if (v.noise) begin
      fft_done = 1'b1;
      @(negedge clk);
      fft_done = 1'b0;
    end
    w = 0;
    while (fs_cnt == fs0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    ok = (fs_cnt != fs0);
    chk({tag, "_fft_start_seen"}, FW'(ok), FW'(1));
    if (ok) chk({tag, "_start_to_launch"}, FW'(fs_cyc - st_cyc), FW'(2 * W + 2));
  endtask

  task automatic finish_core(input vec_t v);
    fft_out_re_flat = v.co_re;
    fft_out_im_flat = v.co_im;
    repeat (int'(v.dly)) @(negedge clk);
    if (v.noise) begin
      start = 1'b1; re_base = 32'h100; im_base = 32'h200;
      @(negedge clk);
      start = 1'b0;
    end
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    fft_out_re_flat = rnd128();
    fft_out_im_flat = rnd128();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int dn0, fs0, w;
    bit ok;
    logic [31:0] ea, ed;
    preload(v);
    dn0 = dn_cnt;
    fs0 = fs_cnt;
    launch(v, tag, ok);
    if (ok) begin
      finish_core(v);
      w = 0;
      while (dn_cnt == dn0 && w < 60) begin
        @(negedge clk);
        w++;
      end
      chk({tag, "_done_seen"}, FW'(dn_cnt != dn0), FW'(1));
      chk({tag, "_fftdone_to_done"}, FW'(dn_cyc - fd_cyc), FW'(2 * W + 1));
      chk({tag, "_busy_after"}, FW'(busy), FW'(0));
      chk({tag, "_in_re"}, fft_in_re_flat, v.x_in_re);
      chk({tag, "_in_im"}, fft_in_im_flat, v.x_in_im);
      chk({tag, "_nwrites"}, FW'(wr_q.size()), FW'(2 * W));
      for (int j = 0; j < wr_q.size() && j < 2 * W; j++) begin
        ea = align(j < W ? v.rb : v.ib) + 32'(4 * (j % W));
        ed = (j < W) ? v.x_wb_re[(j % W) * 32 +: 32] : v.x_wb_im[(j % W) * 32 +: 32];
        chk($sformatf("%s_wr%0d", tag, j), FW'(wr_q[j]), FW'({ea, ed}));
      end
      repeat (25) @(negedge clk);
      chk({tag, "_one_launch"}, FW'(fs_cnt - fs0), FW'(1));
      chk({tag, "_one_done"}, FW'(dn_cnt - dn0), FW'(1));
    end
  endtask

  localparam logic [FW-1:0] CORE_RE = {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
  localparam logic [FW-1:0] CORE_IM = {16'hFFF9, 16'hFFFA, 16'hFFFB, 16'hFFFC,
                                       16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000};
  localparam logic [FW-1:0] WB_RE = {32'h00070006, 32'h00050004, 32'h00030002, 32'h00010000};
  localparam logic [FW-1:0] WB_IM = {32'hFFF9FFFA, 32'hFFFBFFFC, 32'hFFFDFFFE, 32'hFFFF0000};

  initial begin
    bit ok;
    int w;
    // Directed: impulse / write-back, packing order with noise, misaligned bases.
    tv[0] = '{rb: 32'd1000, ib: 32'd2000, re_w: {96'h0, 32'h00007FFF}, im_w: '0,
              co_re: CORE_RE, co_im: CORE_IM, dly: 4'd5, noise: 1'b0, rnd: 1'b0,
              x_in_re: {112'h0, 16'h7FFF}, x_in_im: '0, x_wb_re: WB_RE, x_wb_im: WB_IM};
    tv[1] = '{rb: 32'd1000, ib: 32'd2000,
              re_w: {32'h00080007, 32'h00060005, 32'h00040003, 32'h00020001},
              im_w: {32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888},
              co_re: CORE_RE, co_im: CORE_IM, dly: 4'd2, noise: 1'b1, rnd: 1'b0,
              x_in_re: {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
              x_in_im: {16'h1111, 16'h2222, 16'h3333, 16'h4444,
                        16'h5555, 16'h6666, 16'h7777, 16'h8888},
              x_wb_re: WB_RE, x_wb_im: WB_IM};
    tv[2] = '{rb: 32'd1003, ib: 32'd2002, re_w: {96'h0, 32'h00007FFF},
              im_w: {96'h0, 32'h1234ABCD},
              co_re: CORE_RE, co_im: CORE_IM, dly: 4'd0, noise: 1'b0, rnd: 1'b0,
              x_in_re: {112'h0, 16'h7FFF}, x_in_im: {96'h0, 16'h1234, 16'hABCD},
              x_wb_re: WB_RE, x_wb_im: WB_IM};
    for (int i = 3; i < NV; i++) begin
      tv[i].rb    = 32'h4000 + $urandom_range(0, 1023);
      tv[i].ib    = 32'h8000 + $urandom_range(0, 1023);
      tv[i].re_w  = rnd128();
      tv[i].im_w  = rnd128();
      tv[i].co_re = rnd128();
      tv[i].co_im = rnd128();
      tv[i].dly   = 4'($urandom_range(0, 7));
      tv[i].noise = 1'($urandom_range(0, 1));
      tv[i].rnd   = 1'b1;
    end
    for (int i = 0; i < NV; i++) begin
      if (tv[i].rnd) begin
        tv[i].x_in_re = words_to_samples(tv[i].re_w);
        tv[i].x_in_im = words_to_samples(tv[i].im_w);
        tv[i].x_wb_re = samples_to_words(tv[i].co_re);
        tv[i].x_wb_im = samples_to_words(tv[i].co_im);
      end
    end

    // Reset state
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", FW'(busy), FW'(0));
    chk("rst_done", FW'(done), FW'(0));
    chk("rst_strobes", FW'({mem_rd_en, mem_wr_en, fft_start}), FW'(0));
    chk("rst_addr", FW'(mem_addr), FW'(0));
    chk("rst_wdata", FW'(mem_wdata), FW'(0));
    chk("rst_in_re", fft_in_re_flat, '0);
    chk("rst_in_im", fft_in_im_flat, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(tv[i], $sformatf("v%0d", i));

    // Reset during the third write-back cycle
    preload(tv[1]);
    launch(tv[0], "rstwr", ok);
    if (ok) begin
      finish_core(tv[0]);
      w = 0;
      while (wr_q.size() < 2 && w < 40) begin
        @(negedge clk);
        w++;
      end
      chk("rstwr_in_wr", FW'(mem_wr_en), FW'(1));
      #1 reset = 1'b1;
      #1;
      chk("rstwr_wr_drop", FW'(mem_wr_en), FW'(0));
      chk("rstwr_busy", FW'(busy), FW'(0));
      chk("rstwr_in_clr", fft_in_re_flat, '0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rstwr_nwrites", FW'(wr_q.size()), FW'(2));
    end
    run_vec(tv[3], "after_rst");

    chk("rd_wr_overlap", FW'(overlap), FW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_dma_engine.md
Name: fft_dma_engine

Overview:
- Data mover between the CPU's word-wide data memory and the FFT core.
- On `start` it reads packed Q1.15 real and imaginary samples from two memory regions, unpacks them onto the core's flat input buses, and launches the core.
- It captures the core's flat output buses when the core finishes, repacks them, writes them back in place, then pulses `done`.
- It sits between the CPU's FFT custom-instruction issue logic and the FFT core, sharing the data memory port.

Parameters:
- FFT_N, 8, number of complex points; even, at least 2.
- DATA_W, 16, sample width (Q1.15).
- ADDR_W, 32, byte-address width.
- W (localparam), FFT_N/2, 32-bit words per region.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; honoured only in IDLE.
- re_base  in  ADDR_W  byte address of the real region; sampled on accepted start.
- im_base  in  ADDR_W  byte address of the imaginary region; sampled on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when write-back completes.
- mem_addr  out  ADDR_W  byte address, always word aligned.
- mem_rd_en  out  1  read strobe; data returns on mem_rdata the next cycle.
- mem_wr_en  out  1  write strobe; full 32-bit word.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, 1-cycle latency.
- fft_start  out  1  one-cycle pulse to the FFT core.
- fft_done  in  1  core completion; level or pulse.
- fft_in_re_flat  out  FFT_N*DATA_W  sample i occupies [i*DATA_W +: DATA_W].
- fft_in_im_flat  out  FFT_N*DATA_W  same layout as fft_in_re_flat.
- fft_out_re_flat  in  FFT_N*DATA_W  core result, same layout; valid when fft_done is high.
- fft_out_im_flat  in  FFT_N*DATA_W  same as fft_out_re_flat.

Behaviour:
- Reset values:
  - State returns to IDLE.
  - busy, done, mem_rd_en, mem_wr_en, fft_start are 0.
  - mem_addr, mem_wdata, both fft_in flat buses, the result buffers and the latched bases are 0.
- Packing rule: memory word k = {sample[2k+1], sample[2k]}, with sample 2k in the low half.
- Address rule: latched base has bits[1:0] forced to 0; word k is at base + 4k.
- States: IDLE, RD, DRAIN, LAUNCH, WAIT, WR, FIN.
- IDLE:
  - On start=1, latch both bases, clear the word counter, go to RD.
  - start is ignored in every other state.
- RD (2W cycles), one read issued per cycle:
  - Cycles 0..W-1 read the RE words; cycles W..2W-1 read the IM words.
  - mem_rd_en=1 throughout.
  - Read data is captured one cycle after issue into the matching fft_in slot pair, so capture overlaps the next issue.
- DRAIN (1 cycle): mem_rd_en=0; capture the last IM word.
- LAUNCH (1 cycle): fft_start=1.
- WAIT:
  - Hold until fft_done=1.
  - On that cycle, latch fft_out_re_flat and fft_out_im_flat into internal result buffers, then go to WR.
  - fft_done seen outside WAIT is ignored.
- WR (2W cycles): mem_wr_en=1 each cycle; RE words 0..W-1 first, then IM words 0..W-1, packed from the result buffers.
- FIN (1 cycle): done=1, then return to IDLE.
- fft_in buses hold their values until the next accepted start overwrites them slot by slot.
- Latency:
  - start accepted at cycle 0 gives fft_start at cycle 2W+2.
  - If fft_done arrives at cycle D, the last write is at D+2W and done at D+2W+1.
- mem_rd_en and mem_wr_en are never both high in the same cycle.
- Reset mid-operation aborts immediately:
  - No further memory writes, and partial writes are not undone.
  - fft_in buses clear to 0.
- busy rises the cycle after start is accepted and falls in the same cycle the state returns to IDLE.

Test Plan:
- Impulse: RE word at 1000 = 0x00007FFF, all other RE and IM words 0, re_base=1000, im_base=2000, FFT_N=8 → fft_in_re slot0=0x7FFF, other slots 0; fft_start at cycle 10 after start.
- Packing order: RE words 0x00020001, 0x00040003, 0x00060005, 0x00080007 → fft_in_re slots 0..7 = 1..8.
- Write-back: with stub core output re[i]=i, im[i]=-i and fft_done after 5 cycles → mem[1000..1012] = 0x00010000, 0x00030002, 0x00050004, 0x00070006; IM words = 0xFFFF0000, 0xFFFDFFFE, 0xFFFBFFFC, 0xFFF9FFFA; done 9 cycles after fft_done.
- Misaligned base: re_base=1003 → all RE accesses use addresses 1000..1012.
- start asserted during WAIT, and fft_done pulsed during RD → both ignored; exactly one fft_start and one done per accepted start.
- Reset asserted in the third WR cycle → mem_wr_en drops asynchronously, only 2 words written, busy=0, engine accepts a fresh start normally.
